digital_tube_receiver: RTL and testbench

- Receiving end of the 74HC595-style serial link that drives the six-digit seven-segment display.
- Samples the serial lines `shcp`, `stcp`, `ds` and `oe` in the system clock domain and deserialises each 14-bit word into `seg`/`sel`.
- Reassembles the six scanned digits into a 48-bit frame laid out in the same `{digit5..digit0}` format the display-data path consumes.
- Used for board-to-board mirroring and as a loopback checker on the display path.

---
 rtl/digital_tube_receiver.sv | 129 ++++++++++++
 tb/tb_digital_tube_receiver.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/digital_tube_receiver.sv
// Receiving end of the 74HC595-style seven-segment serial link: synchronises the
// serial lines, deserialises 14-bit words into seg/sel and reassembles six-digit frames.
module digital_tube_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        shcp,
  input  logic        stcp,
  input  logic        ds,
  input  logic        oe,
  output logic [7:0]  seg_o,
  output logic [5:0]  sel_o,
  output logic        blank,
  output logic        latch_valid,
  output logic [47:0] frame_data,
  output logic        frame_valid,
  output logic        len_err,
  output logic        sel_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [SYNC_STAGES:0]   shcp_sync;
  logic [SYNC_STAGES:0]   stcp_sync;
  logic [SYNC_STAGES-1:0] ds_sync;
  logic [SYNC_STAGES-2:0] oe_sync;

  logic        shcp_rise;
  logic        stcp_rise;
  logic        ds_s;
  logic [13:0] shift_reg;
  logic [3:0]  bit_cnt;
  logic [47:0] frame_buf;
  logic [5:0]  mask;
  logic [5:0]  sel_word;
  logic        sel_onehot;
  logic [TW-1:0] timeout_cnt;

  // The last stage of each chain is compared against one extra flop for edge detection;
  // ds is read at the same depth as the newer shcp sample so data lines up with its edge.
  assign shcp_rise  = shcp_sync[SYNC_STAGES-1] & ~shcp_sync[SYNC_STAGES];
  assign stcp_rise  = stcp_sync[SYNC_STAGES-1] & ~stcp_sync[SYNC_STAGES];
  assign ds_s       = ds_sync[SYNC_STAGES-1];
  assign sel_word   = shift_reg[5:0];
  assign sel_onehot = (sel_word != 6'd0) && ((sel_word & (sel_word - 6'd1)) == 6'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shcp_sync <= '0;
      stcp_sync <= '0;
      ds_sync   <= '0;
      oe_sync   <= '0;
      blank     <= 1'b1;
    end else begin
      shcp_sync  <= {shcp_sync[SYNC_STAGES-1:0], shcp};
      stcp_sync  <= {stcp_sync[SYNC_STAGES-1:0], stcp};
      ds_sync    <= {ds_sync[SYNC_STAGES-2:0], ds};
      oe_sync[0] <= oe;
      for (int i = 1; i < SYNC_STAGES - 1; i++) begin
        oe_sync[i] <= oe_sync[i-1];
      end
      // blank acts as the final oe stage so it can sit at 1 during reset
      blank <= oe_sync[SYNC_STAGES-2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg   <= '0;
      bit_cnt     <= '0;
      seg_o       <= 8'hFF;
      sel_o       <= '0;
      latch_valid <= 1'b0;
      len_err     <= 1'b0;
      sel_err     <= 1'b0;
      frame_valid <= 1'b0;
      frame_buf   <= '1;
      frame_data  <= '1;
      mask        <= '0;
      timeout_cnt <= '0;
    end else begin
      latch_valid <= 1'b0;
      len_err     <= 1'b0;
      sel_err     <= 1'b0;
      frame_valid <= 1'b0;

      if (shcp_rise) begin
        shift_reg <= {shift_reg[12:0], ds_s};
        if (bit_cnt != 4'd15) begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end

      // A coincident shift and latch stores the pre-shift word, like the real 74HC595
      if (stcp_rise) begin
        seg_o       <= shift_reg[13:6];
        sel_o       <= sel_word;
        latch_valid <= 1'b1;
        len_err     <= (bit_cnt != 4'd14);
        bit_cnt     <= shcp_rise ? 4'd1 : 4'd0;
        if (sel_onehot) begin
          for (int k = 0; k < 6; k++) begin
            if (sel_word[k]) begin
              frame_buf[k*8 +: 8] <= shift_reg[13:6];
            end
          end
          mask <= mask | sel_word;
        end else begin
          sel_err <= 1'b1;
        end
      end else if (mask == 6'h3F) begin
        frame_data  <= frame_buf;
        frame_valid <= 1'b1;
        mask        <= '0;
      end else if (timeout_cnt == TW'(TIMEOUT)) begin
        mask <= '0;
      end

      if (stcp_rise) begin
        timeout_cnt <= '0;
      end else if (timeout_cnt != TW'(TIMEOUT)) begin
        timeout_cnt <= timeout_cnt + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_digital_tube_receiver.sv
// Self-checking bench for digital_tube_receiver: drives the serial link slowly and
// compares every latch against a word/frame-level reference model.
module tb_digital_tube_receiver;

  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 400;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        shcp = 1'b0;
  logic        stcp = 1'b0;
  logic        ds = 1'b0;
  logic        oe = 1'b0;
  logic [7:0]  seg_o;
  logic [5:0]  sel_o;
  logic        blank;
  logic        latch_valid;
  logic [47:0] frame_data;
  logic        frame_valid;
  logic        len_err;
  logic        sel_err;

  digital_tube_receiver #(.SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .shcp(shcp), .stcp(stcp), .ds(ds), .oe(oe),
    .seg_o(seg_o), .sel_o(sel_o), .blank(blank), .latch_valid(latch_valid),
    .frame_data(frame_data), .frame_valid(frame_valid), .len_err(len_err), .sel_err(sel_err)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Pulse counters and a detector for any pulse wider than one cycle
  int lv_cnt = 0, fv_cnt = 0, le_cnt = 0, se_cnt = 0, wide_cnt = 0;
  logic [3:0] prev_pulses = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_pulses = '0;
    end else begin
      lv_cnt += int'(latch_valid);
      fv_cnt += int'(frame_valid);
      le_cnt += int'(len_err);
      se_cnt += int'(sel_err);
      wide_cnt += $countones({sel_err, len_err, frame_valid, latch_valid} & prev_pulses);
      prev_pulses = {sel_err, len_err, frame_valid, latch_valid};
    end
  end

  // Reference model: a 14-bit window of the last bits sent, and the set of digits seen
  logic [13:0] m_sr;
  int          m_cnt;
  logic [7:0]  m_buf [6];
  logic [5:0]  m_seen;
  logic [7:0]  m_seg;
  logic [5:0]  m_sel;
  logic [47:0] m_frame;
  int e_lv = 0, e_fv = 0, e_le = 0, e_se = 0;

  task automatic model_reset();
    m_sr = '0; m_cnt = 0; m_seen = '0; m_seg = 8'hFF; m_sel = '0;
    m_frame = 48'hFFFF_FFFF_FFFF;
    for (int k = 0; k < 6; k++) m_buf[k] = 8'hFF;
  endtask

  task automatic model_latch(input logic [13:0] word, input int cnt);
    m_seg = word[13:6];
    m_sel = word[5:0];
    e_lv++;
    if (cnt != 14) e_le++;
    if ($countones(m_sel) == 1) begin
      for (int k = 0; k < 6; k++) if (m_sel[k]) m_buf[k] = m_seg;
      m_seen = m_seen | m_sel;
      if (m_seen == 6'h3F) begin
        e_fv++;
        m_frame = {m_buf[5], m_buf[4], m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
        m_seen = '0;
      end
    end else begin
      e_se++;
    end
  endtask

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_output(input string tag);
    check({tag, ".seg"}, 48'(seg_o), 48'(m_seg));
    check({tag, ".sel"}, 48'(sel_o), 48'(m_sel));
    check({tag, ".latch_cnt"}, 48'(lv_cnt), 48'(e_lv));
    check({tag, ".len_err_cnt"}, 48'(le_cnt), 48'(e_le));
    check({tag, ".sel_err_cnt"}, 48'(se_cnt), 48'(e_se));
    check({tag, ".frame_cnt"}, 48'(fv_cnt), 48'(e_fv));
    check({tag, ".frame_data"}, frame_data, m_frame);
  endtask

  task automatic shift_bit(input logic b);
    ds = b;
    wait_clk(4);
    shcp = 1'b1;
    wait_clk(4);
    shcp = 1'b0;
    m_sr = {m_sr[12:0], b};
    if (m_cnt < 15) m_cnt++;
  endtask

  task automatic latch_word(input string tag);
    stcp = 1'b1;
    wait_clk(4);
    stcp = 1'b0;
    model_latch(m_sr, m_cnt);
    m_cnt = 0;
    wait_clk(4);
    check_output(tag);
  endtask

  task automatic shift_and_latch(input logic b, input string tag);
    ds = b;
    wait_clk(4);
    shcp = 1'b1;
    stcp = 1'b1;
    wait_clk(4);
    shcp = 1'b0;
    stcp = 1'b0;
    model_latch(m_sr, m_cnt);
    m_sr = {m_sr[12:0], b};
    m_cnt = 1;
    wait_clk(4);
    check_output(tag);
  endtask

  task automatic apply_stimulus(input logic [13:0] word, input int nbits, input string tag);
    for (int i = nbits - 1; i >= 0; i--) shift_bit(word[i]);
    latch_word(tag);
  endtask

  task automatic send_digit(input logic [7:0] seg, input logic [5:0] sel, input string tag);
    apply_stimulus({seg, sel}, 14, tag);
  endtask

  task automatic idle(input int n);
    wait_clk(n);
    if (n > TIMEOUT) m_seen = '0;
  endtask

  logic [7:0] segs_a [6] = '{8'h63, 8'h91, 8'h03, 8'h03, 8'h49, 8'h61};
  logic [7:0] segs_b [6] = '{8'h61, 8'h31, 8'h03, 8'h63, 8'h91, 8'h49};
  int perm [6];

  initial begin
    model_reset();

    // Reset held with random serial activity on every input
    rst_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("reset_state",
            {seg_o, sel_o, blank, frame_data, latch_valid, frame_valid, len_err, sel_err},
            {8'hFF, 6'h00, 1'b1, 48'hFFFF_FFFF_FFFF, 4'b0000});
      {shcp, stcp, ds, oe} = 4'($urandom);
    end
    {shcp, stcp, ds, oe} = 4'b0000;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(6);
    check("post_reset.seg", 48'(seg_o), 48'hFF);
    check("post_reset.blank", 48'(blank), 48'h0);

    send_digit(8'h61, 6'h20, "single");

    for (int i = 0; i < 6; i++) send_digit(segs_a[i], 6'h20 >> i, "frame_a");
    check("frame_a.data", frame_data, 48'h6391_0303_4961);
    for (int i = 0; i < 6; i++) send_digit(segs_b[i], 6'h20 >> i, "frame_b");
    check("frame_b.data", frame_data, 48'h6131_0363_9149);

    apply_stimulus({8'h49, 6'h02}, 13, "short_word");

    send_digit(8'h11, 6'h20, "err_frame");
    send_digit(8'h22, 6'h10, "err_frame");
    send_digit(8'h33, 6'h08, "err_frame");
    send_digit(8'h55, 6'h21, "bad_sel");
    send_digit(8'h44, 6'h04, "err_frame");
    send_digit(8'h66, 6'h02, "err_frame");
    send_digit(8'h77, 6'h01, "err_frame");

    for (int i = 0; i < 3; i++) send_digit(8'($urandom), 6'h20 >> i, "partial");
    idle(TIMEOUT + 10);
    for (int i = 0; i < 6; i++) send_digit(8'($urandom), 6'h01 << i, "after_timeout");

    // 13 bits then a shift coincident with the latch, then a completing word
    for (int i = 13; i >= 1; i--) shift_bit(1'($urandom));
    shift_and_latch(1'($urandom), "simultaneous");
    for (int i = 12; i >= 0; i--) shift_bit(1'($urandom));
    latch_word("after_simultaneous");

    oe = 1'b1;
    wait_clk(SYNC_STAGES - 1);
    check("blank_early", 48'(blank), 48'h0);
    wait_clk(1);
    check("blank_set", 48'(blank), 48'h1);
    send_digit(8'h5A, 6'h08, "capture_blanked");
    oe = 1'b0;
    wait_clk(SYNC_STAGES);
    check("blank_clear", 48'(blank), 48'h0);

    for (int i = 0; i < 6; i++) perm[i] = i;
    for (int i = 5; i > 0; i--) begin
      int j, t;
      j = int'($urandom_range(i, 0));
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int i = 0; i < 6; i++) send_digit(8'($urandom), 6'h01 << perm[i], "random_frame");

    // Reset mid-word must throw away the partial bit count
    for (int i = 0; i < 5; i++) shift_bit(1'($urandom));
    rst_n = 1'b0;
    wait_clk(3);
    model_reset();
    check("mid_reset.frame", frame_data, m_frame);
    check("mid_reset.seg", 48'(seg_o), 48'hFF);
    rst_n = 1'b1;
    wait_clk(4);
    send_digit(8'h3C, 6'h04, "after_mid_reset");

    check("pulse_width", 48'(wide_cnt), 48'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
